uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_pkg.sv | 46 ++++
 rtl/uart_bit_timer.sv | 37 +++
 rtl/uart_tx_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit controller.
//   - tx_state_e   : controller state enumeration
//   - SIZE_*       : encoding of the Size input (data bits per frame)
//   - frame_cfg_t  : per-frame configuration captured when a word is loaded
//   - BAUD_W_DEF   : default width of the baud divisor
package uart_pkg;

  localparam int unsigned BAUD_W_DEF = 16;
  localparam int unsigned SIZE_W     = 2;
  localparam int unsigned BITCNT_W   = 3;
  localparam int unsigned DATA_W     = 8;

  // Size encoding: number of data bits is code + 5
  localparam logic [SIZE_W-1:0] SIZE_5 = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_6 = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_7 = 2'd2;
  localparam logic [SIZE_W-1:0] SIZE_8 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } tx_state_e;

  typedef struct packed {
    logic [SIZE_W-1:0] size;
    logic              parity_en;
    logic              parity_odd;
    logic              two_stop;
  } frame_cfg_t;

  // Index of the last data bit sent for a given Size code
  function automatic logic [BITCNT_W-1:0] last_bit_idx(input logic [SIZE_W-1:0] size);
    case (size)
      SIZE_5:  return 3'd4;
      SIZE_6:  return 3'd5;
      SIZE_7:  return 3'd6;
      SIZE_8:  return 3'd7;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the UART transmitter.
// Loads (period - 1) on load and counts down to zero, then holds.
//   clk, rst       : clock, synchronous active-high reset
//   load           : start a new bit period
//   period_m1      : cycles per bit minus one
//   bit_end_c      : current cycle is the last cycle of the bit
//   bit_penult_c   : current cycle is the second-to-last cycle of the bit
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_W = BAUD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BAUD_W-1:0] period_m1,
  output logic              bit_end_c,
  output logic              bit_penult_c
);

  logic [BAUD_W-1:0] cnt_q;

  // Down-counter; parks at zero between bits
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= period_m1;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - BAUD_W'(1);
    end
  end

  assign bit_end_c    = (cnt_q == '0);
  assign bit_penult_c = (cnt_q == BAUD_W'(1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops words from a TX FIFO and serialises them
// as start / 5..8 data bits (LSB first) / optional parity / 1 or 2 stop bits.
//   Clock, Reset        : clock, synchronous active-high reset
//   Enable              : transmitter enable (checked between frames only)
//   BaudDiv             : clock cycles per bit (0 and 1 behave as 2)
//   Size                : data bits code, 0..3 -> 5..8
//   ParityEn, ParityOdd : parity enable, odd/even select
//   TwoStop             : two stop bits when set
//   FifoEmpty, FifoData : TX FIFO status and head word (bit 8 ignored)
//   FifoRead            : registered pop strobe, high only in LOAD
//   Tx                  : registered serial line, idles high
//   Busy                : high in every state except IDLE
//   FrameDone           : high during the final cycle of the last stop bit
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_W = BAUD_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic [BAUD_W-1:0] BaudDiv,
  input  logic [1:0]        Size,
  input  logic              ParityEn,
  input  logic              ParityOdd,
  input  logic              TwoStop,
  input  logic              FifoEmpty,
  input  logic [8:0]        FifoData,
  output logic              FifoRead,
  output logic              Tx,
  output logic              Busy,
  output logic              FrameDone
);

  tx_state_e             state_q;
  logic [DATA_W-1:0]     shift_q;
  logic [BITCNT_W-1:0]   bit_idx_q;
  logic                  par_q;
  logic                  stop_left_q;
  frame_cfg_t            cfg_q;
  logic [BAUD_W-1:0]     baud_q;

  logic                  tmr_load_c;
  logic [BAUD_W-1:0]     tmr_period_c;
  logic                  bit_end_c;
  logic                  bit_penult_c;
  logic                  start_frame_c;

  // Only the low byte of the FIFO word is transmitted
  logic                  unused_fifo_msb;
  assign unused_fifo_msb = FifoData[8];

  // Cycles per bit minus one, with divisors below 2 clamped to 2
  function automatic logic [BAUD_W-1:0] period_m1(input logic [BAUD_W-1:0] div);
    return (div < BAUD_W'(2)) ? BAUD_W'(1) : div - BAUD_W'(1);
  endfunction

  assign start_frame_c = Enable & ~FifoEmpty;

  // The divisor is latched at the end of LOAD, so START takes it straight from the port
  assign tmr_period_c = period_m1((state_q == ST_LOAD) ? BaudDiv : baud_q);

  // Restart the timer at every bit boundary inside a frame
  always_comb begin
    tmr_load_c = 1'b0;
    case (state_q)
      ST_LOAD:                      tmr_load_c = 1'b1;
      ST_START, ST_DATA, ST_PARITY: tmr_load_c = bit_end_c;
      ST_STOP:                      tmr_load_c = bit_end_c & stop_left_q;
      default:                      tmr_load_c = 1'b0;
    endcase
  end

  uart_bit_timer #(
    .BAUD_W (BAUD_W)
  ) u_bit_timer (
    .clk          (Clock),
    .rst          (Reset),
    .load         (tmr_load_c),
    .period_m1    (tmr_period_c),
    .bit_end_c    (bit_end_c),
    .bit_penult_c (bit_penult_c)
  );

  // Frame sequencer with registered line, strobe and status outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      par_q       <= 1'b0;
      stop_left_q <= 1'b0;
      cfg_q       <= '0;
      baud_q      <= '0;
      Tx          <= 1'b1;
      FifoRead    <= 1'b0;
      Busy        <= 1'b0;
      FrameDone   <= 1'b0;
    end else begin
      FifoRead  <= 1'b0;
      FrameDone <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          Tx <= 1'b1;
          if (start_frame_c) begin
            state_q  <= ST_LOAD;
            FifoRead <= 1'b1;
            Busy     <= 1'b1;
          end
        end

        ST_LOAD: begin
          shift_q          <= FifoData[DATA_W-1:0];
          cfg_q.size       <= Size;
          cfg_q.parity_en  <= ParityEn;
          cfg_q.parity_odd <= ParityOdd;
          cfg_q.two_stop   <= TwoStop;
          baud_q           <= BaudDiv;
          bit_idx_q        <= '0;
          par_q            <= 1'b0;
          stop_left_q      <= 1'b0;
          Tx               <= 1'b0;
          state_q          <= ST_START;
        end

        ST_START: begin
          if (bit_end_c) begin
            Tx        <= shift_q[0];
            par_q     <= shift_q[0];
            shift_q   <= {1'b0, shift_q[DATA_W-1:1]};
            bit_idx_q <= '0;
            state_q   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (bit_end_c) begin
            if (bit_idx_q == last_bit_idx(cfg_q.size)) begin
              if (cfg_q.parity_en) begin
                Tx      <= par_q ^ cfg_q.parity_odd;
                state_q <= ST_PARITY;
              end else begin
                Tx          <= 1'b1;
                stop_left_q <= cfg_q.two_stop;
                state_q     <= ST_STOP;
              end
            end else begin
              Tx        <= shift_q[0];
              par_q     <= par_q ^ shift_q[0];
              shift_q   <= {1'b0, shift_q[DATA_W-1:1]};
              bit_idx_q <= bit_idx_q + BITCNT_W'(1);
            end
          end
        end

        ST_PARITY: begin
          if (bit_end_c) begin
            Tx          <= 1'b1;
            stop_left_q <= cfg_q.two_stop;
            state_q     <= ST_STOP;
          end
        end

        ST_STOP: begin
          // Raise FrameDone so it lines up with the final stop cycle
          if (bit_penult_c && !stop_left_q) begin
            FrameDone <= 1'b1;
          end
          if (bit_end_c) begin
            if (stop_left_q) begin
              stop_left_q <= 1'b0;
            end else if (start_frame_c) begin
              state_q  <= ST_LOAD;
              FifoRead <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              Busy    <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          Tx      <= 1'b1;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a frame-level model predicts the
// per-cycle line and strobes, plus literal waveform expectations.
module tb_uart_tx_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] baud_div;
  logic [1:0]  size;
  logic        par_en;
  logic        par_odd;
  logic        two_stop;
  logic        fifo_empty;
  logic [8:0]  fifo_data;
  logic        fifo_read;
  logic        tx;
  logic        busy;
  logic        frame_done;

  uart_tx_ctrl dut (
    .Clock     (clk),
    .Reset     (rst),
    .Enable    (en),
    .BaudDiv   (baud_div),
    .Size      (size),
    .ParityEn  (par_en),
    .ParityOdd (par_odd),
    .TwoStop   (two_stop),
    .FifoEmpty (fifo_empty),
    .FifoData  (fifo_data),
    .FifoRead  (fifo_read),
    .Tx        (tx),
    .Busy      (busy),
    .FrameDone (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Simple FIFO: main process writes, pops follow the DUT strobe
  logic [8:0] words [0:31];
  int         wr = 0;
  int         rd = 0;
  assign fifo_empty = (rd == wr);
  assign fifo_data  = words[rd[4:0]];

  always @(posedge clk) begin
    if (fifo_read && rd != wr) rd <= rd + 1;
  end

  // Frame model: on the edge that ends LOAD, the whole frame is expanded
  // into a queue of per-cycle line values.
  logic exp_tx, exp_rd, exp_busy, exp_done;
  bit   mq[$];
  int   m_phase = 0;  // 0 idle, 1 load cycle in progress, 2 frame on the line

  always @(posedge clk) begin
    int p;
    int nb;
    bit par;
    bit b;
    if (rst) begin
      m_phase = 0;
      mq.delete();
      exp_tx   <= 1'b1;
      exp_rd   <= 1'b0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
    end else begin
      exp_rd   <= 1'b0;
      exp_done <= 1'b0;
      if (m_phase == 2 && mq.size() != 0) begin
        exp_tx   <= mq.pop_front();
        exp_done <= (mq.size() == 0);
      end else if (m_phase == 1) begin
        p   = (baud_div < 16'd2) ? 2 : int'(baud_div);
        nb  = int'(size) + 5;
        par = 1'b0;
        repeat (p) mq.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
          b   = fifo_data[i];
          par = par ^ b;
          repeat (p) mq.push_back(b);
        end
        if (par_en) repeat (p) mq.push_back(par ^ par_odd);
        repeat (two_stop ? 2 * p : p) mq.push_back(1'b1);
        exp_tx  <= mq.pop_front();
        m_phase = 2;
      end else begin
        exp_tx <= 1'b1;
        if (en && !fifo_empty) begin
          m_phase = 1;
          exp_rd   <= 1'b1;
          exp_busy <= 1'b1;
        end else begin
          m_phase = 0;
          exp_busy <= 1'b0;
        end
      end
    end
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  logic log_tx[$];
  logic log_rd[$];
  logic log_busy[$];
  logic log_done[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, log_tx.size(), got, want);
    end
  endtask

  // One clock: sample on the falling edge, compare with the model, log
  task automatic cyc();
    @(negedge clk);
    chk("tx",         32'(tx),         32'(exp_tx));
    chk("fifo_read",  32'(fifo_read),  32'(exp_rd));
    chk("busy",       32'(busy),       32'(exp_busy));
    chk("frame_done", 32'(frame_done), 32'(exp_done));
    log_tx.push_back(tx);
    log_rd.push_back(fifo_read);
    log_busy.push_back(busy);
    log_done.push_back(frame_done);
  endtask

  task automatic run_to(input int idx);
    while (log_tx.size() <= idx) cyc();
  endtask

  task automatic push(input logic [8:0] w);
    words[wr[4:0]] = w;
    wr = wr + 1;
  endtask

  task automatic wait_start(output int s);
    bit found;
    found = 1'b0;
    s = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      cyc();
      if (log_tx[log_tx.size() - 1] == 1'b0) begin
        found = 1'b1;
        s = log_tx.size() - 1;
      end
    end
    if (!found) begin
      chk("start_timeout", 32'd0, 32'd1);
      s = log_tx.size() - 1;
    end
  endtask

  function automatic int first_low(input int from);
    for (int i = from; i < log_tx.size(); i++) if (log_tx[i] == 1'b0) return i;
    return -1;
  endfunction

  function automatic int first_done(input int from);
    for (int i = from; i < log_done.size(); i++) if (log_done[i] == 1'b1) return i;
    return -1;
  endfunction

  function automatic int count_rd(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (log_rd[i] == 1'b1) n++;
    return n;
  endfunction

  function automatic int count_done(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (log_done[i] == 1'b1) n++;
    return n;
  endfunction

  // Check first and last cycle of each bit against a hand-written pattern
  task automatic chk_frame(input string tag, input int s, input int nb, input int p,
                           input logic [15:0] pat);
    for (int k = 0; k < nb; k++) begin
      chk($sformatf("%s_bit%0d_head", tag, k), 32'(log_tx[s + p * k]), 32'(pat[k]));
      chk($sformatf("%s_bit%0d_tail", tag, k), 32'(log_tx[s + p * k + p - 1]), 32'(pat[k]));
    end
  endtask

  initial begin
    int s;
    int s2;
    int d1;
    int a;
    int viol;

    rst = 1'b1; en = 1'b0; baud_div = 16'd4; size = 2'd3;
    par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b0;
    repeat (3) cyc();
    chk("rst_tx",   32'(tx),         32'd1);
    chk("rst_busy", 32'(busy),       32'd0);
    chk("rst_rd",   32'(fifo_read),  32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    repeat (2) cyc();

    // 8N1, divisor 4, 0xA5
    push(9'h0A5); en = 1'b1;
    wait_start(s);
    run_to(s + 45);
    chk_frame("t1", s, 10, 4, 16'h034A);
    chk("t1_done_pos", 32'(first_done(s) - s), 32'd39);
    chk("t1_done_cnt", 32'(count_done(s, s + 45)), 32'd1);
    chk("t1_load_rd",  32'(log_rd[s - 1]), 32'd1);
    chk("t1_rd_cnt",   32'(count_rd(s - 1, s + 45)), 32'd1);

    // 7E1, 0x41: even parity bit 0
    size = 2'd2; par_en = 1'b1; par_odd = 1'b0;
    push(9'h041);
    wait_start(s);
    run_to(s + 45);
    chk_frame("t2e", s, 10, 4, 16'h0282);
    chk("t2e_done_pos", 32'(first_done(s) - s), 32'd39);

    // 7O1, 0x41: odd parity bit 1; config scrambled mid-frame must not matter
    par_odd = 1'b1;
    push(9'h041);
    wait_start(s);
    size = 2'd3; par_odd = 1'b0; par_en = 1'b0; baud_div = 16'd7;
    run_to(s + 45);
    chk_frame("t2o", s, 10, 4, 16'h0382);
    chk("t2o_done_pos", 32'(first_done(s) - s), 32'd39);

    // 8N2, divisor 3, two queued words back to back
    en = 1'b0; cyc();
    baud_div = 16'd3; size = 2'd3; par_en = 1'b0; two_stop = 1'b1;
    push(9'h03C); push(9'h0C3); en = 1'b1;
    wait_start(s);
    run_to(s + 80);
    d1 = first_done(s);
    chk("t3_done1_pos", 32'(d1 - s), 32'd32);
    if (d1 < 0) d1 = s;
    s2 = first_low(d1 + 1);
    chk("t3_gap",       32'(s2 - d1), 32'd2);
    chk("t3_s2_offset", 32'(s2 - s),  32'd35 - 32'd1);
    if (s2 < 0) s2 = s;
    chk_frame("t3a", s,  11, 3, 16'h0678);
    chk_frame("t3b", s2, 11, 3, 16'h0786);
    chk("t3_done2_pos", 32'(first_done(d1 + 1) - s2), 32'd32);
    chk("t3_rd_cnt",    32'(count_rd(s - 1, s + 80)), 32'd2);

    // Enabled with an empty FIFO for 100 cycles
    two_stop = 1'b0; baud_div = 16'd4;
    a = log_tx.size();
    run_to(a + 99);
    viol = 0;
    for (int i = a; i <= a + 99; i++)
      if (log_tx[i] !== 1'b1 || log_rd[i] !== 1'b0 || log_busy[i] !== 1'b0) viol++;
    chk("t4_idle_viol", 32'(viol), 32'd0);

    // Reset during data bit 3; queued word then goes out as a fresh frame
    push(9'h05A);
    wait_start(s);
    run_to(s + 17);
    push(9'h081);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5_rst_tx",   32'(log_tx[s + 18]),   32'd1);
    chk("t5_rst_busy", 32'(log_busy[s + 18]), 32'd0);
    chk("t5_no_done",  32'(count_done(s, s + 18)), 32'd0);
    run_to(s + 70);
    s2 = first_low(s + 19);
    chk("t5_restart", 32'(s2 - s), 32'd20);
    if (s2 < 0) s2 = s;
    chk_frame("t5", s2, 10, 4, 16'h0302);
    chk("t5_done_pos", 32'(first_done(s2) - s2), 32'd39);

    // Divisor 0 -> 2-cycle bits; Enable dropped mid-data finishes the frame
    baud_div = 16'd0;
    push(9'h033); push(9'h044);
    wait_start(s);
    run_to(s + 6);
    en = 1'b0;
    run_to(s + 40);
    chk_frame("t6", s, 10, 2, 16'h0266);
    chk("t6_done_pos", 32'(first_done(s) - s), 32'd19);
    chk("t6_no_rd",    32'(count_rd(s, s + 40)), 32'd0);
    chk("t6_idle",     32'(log_busy[s + 25]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
